// File: rtl/ddr3_wb_traffic_gen_if.sv
// Pipelined Wishbone bundle between the traffic generator (master) and the DDR3 controller user port (slave).
interface ddr3_wb_traffic_gen_if #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 512,
    parameter int AUX_WIDTH = 16
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [ADDR_BITS-1:0]   addr;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] sel;
    logic [AUX_WIDTH-1:0]   aux;
    logic                   stall;
    logic                   ack;
    logic [DATA_BITS-1:0]   rdata;
    logic [AUX_WIDTH-1:0]   ack_aux;

    modport master (
        output cyc, stb, we, addr, wdata, sel, aux,
        input  stall, ack, rdata, ack_aux
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel, aux,
        output stall, ack, rdata, ack_aux
    );
endinterface

// File: rtl/ddr3_wb_traffic_gen.sv
// Write/read-back traffic generator for the DDR3 controller Wishbone user port,
// with pass/fail, error count, first failing address and a stall/ack watchdog.
//
//  state    | meaning
//  ---------+-----------------------------------------------------
//  S_IDLE   | waiting for i_start after reset
//  S_WRITE  | issuing NUM_BURSTS pattern writes
//  S_WDRAIN | all writes issued, waiting for their acks
//  S_READ   | issuing NUM_BURSTS reads, checking returned data
//  S_RDRAIN | all reads issued, waiting for remaining acks
//  S_DONE   | results held until the next i_start
module ddr3_wb_traffic_gen #(
    parameter int                      WB_ADDR_BITS    = 24,
    parameter int                      WB_DATA_BITS    = 512,
    parameter int                      AUX_WIDTH       = 16,
    parameter logic [WB_ADDR_BITS-1:0] START_ADDR      = '0,
    parameter int                      NUM_BURSTS      = 1024,
    parameter int                      MAX_OUTSTANDING = 8,
    parameter logic [31:0]             PATTERN_SEED    = 32'h0,
    parameter int                      TIMEOUT_CYCLES  = 4096
) (
    input  logic                    i_controller_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic                    o_timeout,
    output logic [15:0]             o_err_count,
    output logic [WB_ADDR_BITS-1:0] o_first_err_addr,
    ddr3_wb_traffic_gen_if.master   wb
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WDRAIN = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_RDRAIN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int CNT_W = $clog2(NUM_BURSTS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LANES = WB_DATA_BITS / 32;

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_BURSTS);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] issue_cnt;
    logic [OUT_W-1:0] outstanding;
    logic [WD_W-1:0]  wd_cnt;
    logic             timeout_q;

    logic active, issuing, stb, accept, ack_valid, rd_ack, mismatch;
    logic wd_run, wd_fire, start_ok;

    function automatic logic [WB_DATA_BITS-1:0] pattern(input logic [15:0] n);
        logic [WB_DATA_BITS-1:0] w;
        w = '0;
        for (int j = 0; j < LANES; j++) begin
            w[j*32 +: 32] = {n, 8'(j), 8'hA5} ^ PATTERN_SEED;
        end
        return w;
    endfunction

    assign active    = state inside {S_WRITE, S_WDRAIN, S_READ, S_RDRAIN};
    assign issuing   = (state == S_WRITE) || (state == S_READ);
    assign stb       = issuing && (issue_cnt < CNT_END) && (outstanding < OUT_MAX);
    assign accept    = stb && !wb.stall;
    assign ack_valid = active && wb.ack && (outstanding != '0);
    assign rd_ack    = ack_valid && ((state == S_READ) || (state == S_RDRAIN));
    assign mismatch  = wb.rdata != pattern(16'(wb.ack_aux));
    assign wd_run    = active && ((outstanding != '0) || stb);
    assign wd_fire   = wd_run && !wb.ack && !accept && (wd_cnt == WD_LAST);
    assign start_ok  = i_start && ((state == S_IDLE) || (state == S_DONE));

    // Request fields derive from issue_cnt, which only moves on accept, so they hold while stalled.
    assign wb.cyc   = active;
    assign wb.stb   = stb;
    assign wb.we    = stb && (state == S_WRITE);
    assign wb.addr  = stb ? START_ADDR + WB_ADDR_BITS'(issue_cnt) : '0;
    assign wb.wdata = (stb && (state == S_WRITE)) ? pattern(16'(issue_cnt)) : '0;
    assign wb.aux   = stb ? AUX_WIDTH'(issue_cnt) : '0;
    // Byte enables are all ones whenever a cycle is open; idle keeps every output low.
    assign wb.sel   = {(WB_DATA_BITS/8){active}};

    assign o_busy    = active;
    assign o_done    = (state == S_DONE);
    assign o_timeout = timeout_q;
    assign o_pass    = o_done && (o_err_count == 16'd0) && !timeout_q;

    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            issue_cnt        <= '0;
            outstanding      <= '0;
            wd_cnt           <= '0;
            timeout_q        <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
        end else if (start_ok) begin
            state            <= S_WRITE;
            issue_cnt        <= '0;
            outstanding      <= '0;
            wd_cnt           <= '0;
            timeout_q        <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
        end else if (wd_fire) begin
            state       <= S_DONE;
            timeout_q   <= 1'b1;
            outstanding <= '0;
            wd_cnt      <= '0;
        end else begin
            if (accept) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end

            if (accept && !ack_valid) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!accept && ack_valid) begin
                outstanding <= outstanding - OUT_W'(1);
            end

            if (wb.ack || accept) begin
                wd_cnt <= '0;
            end else if (wd_run) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (rd_ack && mismatch) begin
                if (o_err_count != 16'hFFFF) begin
                    o_err_count <= o_err_count + 16'd1;
                end
                if (o_err_count == 16'd0) begin
                    o_first_err_addr <= START_ADDR + WB_ADDR_BITS'(wb.ack_aux);
                end
            end

            case (state)
                S_WRITE:  if (issue_cnt == CNT_END) state <= S_WDRAIN;
                S_WDRAIN: if (outstanding == '0) begin
                    state     <= S_READ;
                    issue_cnt <= '0;
                end
                S_READ:   if (issue_cnt == CNT_END) state <= S_RDRAIN;
                S_RDRAIN: if (outstanding == '0) state <= S_DONE;
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_wb_traffic_gen.sv
// Directed bench for ddr3_wb_traffic_gen: scenario table plus hand sequences for reset and late acks.
module tb_ddr3_wb_traffic_gen;
    localparam int AB = 24;
    localparam int DB = 64;
    localparam int AW = 16;
    localparam int NB = 16;
    localparam int TO = 64;
    localparam logic [AB-1:0] START    = 24'hFFFFFE;
    localparam logic [31:0]   SEED     = 32'h1234_5678;
    localparam logic [AB-1:0] BAD_ADDR = 24'h000003;

    typedef struct {
        string         name;
        int            lat_mode;
        bit            stall_alt;
        bit            corrupt;
        bit            stop3;
        bit            poke_start;
        bit            exp_pass;
        bit            exp_timeout;
        int            exp_err;
        logic [AB-1:0] exp_first;
        int            exp_wr;
        int            exp_rd;
        int            exp_max_out;
    } vec_t;

    typedef struct {
        logic [AW-1:0] aux;
        logic [DB-1:0] data;
        int            due;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AB-1:0] first_err;

    ddr3_wb_traffic_gen_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .AUX_WIDTH(AW)) wb ();

    ddr3_wb_traffic_gen #(
        .WB_ADDR_BITS(AB), .WB_DATA_BITS(DB), .AUX_WIDTH(AW), .START_ADDR(START),
        .NUM_BURSTS(NB), .MAX_OUTSTANDING(8), .PATTERN_SEED(SEED), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_controller_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout),
        .o_err_count(err_count), .o_first_err_addr(first_err), .wb(wb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;

    pend_t         pq[$];
    logic [DB-1:0] mem [logic [AB-1:0]];
    int  lat_mode;
    bit  stall_alt, corrupt, stop3, inj, in_test, to_seen, prev_hold;
    int  wr_acc, rd_acc, acks_given, out_b, max_out, cyc_drop, last_ack, to_cycle;
    logic [AB-1:0] h_addr;
    logic [DB-1:0] h_data;
    logic [AW-1:0] h_aux;
    logic          h_we;
    logic [AB-1:0] cap_addr [4];
    logic [DB-1:0] cap_data [4];
    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DB-1:0] exp_pat(input int n);
        logic [DB-1:0] w;
        for (int j = 0; j < DB/32; j++) w[j*32 +: 32] = {16'(n), 8'(j), 8'hA5} ^ SEED;
        return w;
    endfunction

    // Slave model: decides stall/ack mid-cycle, stores writes, returns (optionally corrupted) reads.
    initial begin : slave
        logic          stall_v, ack_v;
        logic [AW-1:0] aux_v;
        logic [DB-1:0] dat_v;
        int            idx, lat;
        wb.stall = 1'b0; wb.ack = 1'b0; wb.rdata = '0; wb.ack_aux = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                pq.delete();
                out_b = 0; prev_hold = 0;
                wb.stall = 1'b0; wb.ack = 1'b0;
            end else begin
                stall_v = (stall_alt && (ncyc % 2 == 1)) || (stop3 && wr_acc >= 3);
                if (prev_hold && !timeout) begin
                    check("hold_stb",  64'(wb.stb),   64'd1);
                    check("hold_we",   64'(wb.we),    64'(h_we));
                    check("hold_addr", 64'(wb.addr),  64'(h_addr));
                    check("hold_data", 64'(wb.wdata), 64'(h_data));
                    check("hold_aux",  64'(wb.aux),   64'(h_aux));
                end
                prev_hold = wb.stb && stall_v;
                h_addr = wb.addr; h_data = wb.wdata; h_aux = wb.aux; h_we = wb.we;
                if (in_test && !done && !wb.cyc) cyc_drop++;
                if (wb.stb && !stall_v) begin
                    dat_v = '0;
                    if (wb.we) begin
                        check("wr_aux",  64'(wb.aux),   64'(wr_acc));
                        check("wr_addr", 64'(wb.addr),  64'(24'(START + 24'(wr_acc))));
                        check("wr_data", 64'(wb.wdata), 64'(exp_pat(wr_acc)));
                        mem[wb.addr] = wb.wdata;
                        if (wr_acc < 4) begin
                            cap_addr[wr_acc] = wb.addr;
                            cap_data[wr_acc] = wb.wdata;
                        end
                        wr_acc++;
                    end else begin
                        check("rd_aux",  64'(wb.aux),  64'(rd_acc));
                        check("rd_addr", 64'(wb.addr), 64'(24'(START + 24'(rd_acc))));
                        dat_v = mem[wb.addr];
                        if (corrupt && wb.addr == BAD_ADDR) dat_v = dat_v ^ 64'h1;
                        rd_acc++;
                    end
                    lat = (lat_mode == 0) ? 1 : (lat_mode == 1) ? 20 : 2 + (int'(wb.aux) * 3) % 7;
                    pq.push_back('{aux: wb.aux, data: dat_v, due: ncyc + lat});
                    out_b++;
                end
                ack_v = 1'b0; aux_v = '0; dat_v = '0;
                if (inj) begin
                    ack_v = 1'b1; dat_v = '1; inj = 0;
                end else if (!(stop3 && acks_given >= 3)) begin
                    idx = -1;
                    for (int i = 0; i < pq.size(); i++) if (idx < 0 && pq[i].due <= ncyc) idx = i;
                    if (idx >= 0) begin
                        ack_v = 1'b1; aux_v = pq[idx].aux; dat_v = pq[idx].data;
                        pq.delete(idx);
                        out_b--; acks_given++; last_ack = ncyc;
                    end
                end
                if (out_b > max_out) max_out = out_b;
                if (timeout && !to_seen) begin
                    to_seen = 1; to_cycle = ncyc;
                end
                wb.stall = stall_v; wb.ack = ack_v; wb.ack_aux = aux_v; wb.rdata = dat_v;
            end
        end
    end

    task automatic setup(input vec_t v);
        lat_mode = v.lat_mode; stall_alt = v.stall_alt; corrupt = v.corrupt; stop3 = v.stop3;
        wr_acc = 0; rd_acc = 0; acks_given = 0; out_b = 0; max_out = 0; cyc_drop = 0;
        last_ack = 0; to_cycle = 0; to_seen = 0; prev_hold = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s status", tag),  64'({busy, done, pass, timeout}), 64'd0);
        check($sformatf("%s bus_ctl", tag), 64'({wb.cyc, wb.stb, wb.we}), 64'd0);
        check($sformatf("%s err", tag),     64'(err_count), 64'd0);
        check($sformatf("%s first", tag),   64'(first_err), 64'd0);
        check($sformatf("%s addr", tag),    64'(wb.addr),   64'd0);
        check($sformatf("%s wdata", tag),   64'(wb.wdata),  64'd0);
        check($sformatf("%s sel", tag),     64'(wb.sel),    64'd0);
        check($sformatf("%s aux", tag),     64'(wb.aux),    64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        bit fin;
        setup(v);
        pulse_start();
        in_test = 1;
        if (v.poke_start) begin
            repeat (30) @(negedge clk);
            pulse_start();
            check($sformatf("%s busy_after_restart", v.name), 64'(busy), 64'd1);
        end
        fin = 0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            fin = done;
        end
        in_test = 0;
        check($sformatf("%s done", v.name),     64'(done),      64'd1);
        check($sformatf("%s pass", v.name),     64'(pass),      64'(v.exp_pass));
        check($sformatf("%s timeout", v.name),  64'(timeout),   64'(v.exp_timeout));
        check($sformatf("%s err", v.name),      64'(err_count), 64'(v.exp_err));
        check($sformatf("%s first", v.name),    64'(first_err), 64'(v.exp_first));
        check($sformatf("%s writes", v.name),   64'(wr_acc),    64'(v.exp_wr));
        check($sformatf("%s reads", v.name),    64'(rd_acc),    64'(v.exp_rd));
        check($sformatf("%s cyc_drop", v.name), 64'(cyc_drop),  64'd0);
        check($sformatf("%s idle_bus", v.name), 64'({wb.cyc, wb.stb, busy}), 64'd0);
        check($sformatf("%s max_out_le8", v.name), 64'(max_out <= 8), 64'd1);
        if (v.exp_max_out >= 0)
            check($sformatf("%s max_out", v.name), 64'(max_out), 64'(v.exp_max_out));
        if (v.exp_timeout)
            check($sformatf("%s timeout_delay", v.name), 64'(to_cycle - last_ack), 64'd65);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL sim_watchdog: got no finish, expected finish before 500000");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        bit reached;
        vecs[0] = '{"zero_lat",    0, 0, 0, 0, 0, 1, 0, 0, 24'h0,    16, 16,  1};
        vecs[1] = '{"stall_lat20", 1, 1, 0, 0, 1, 1, 0, 0, 24'h0,    16, 16,  8};
        vecs[2] = '{"ooo_corrupt", 2, 0, 1, 0, 0, 0, 0, 1, BAD_ADDR, 16, 16, -1};
        vecs[3] = '{"ack_stop",    0, 0, 0, 1, 0, 0, 1, 0, 24'h0,     3,  0, -1};

        start = 1'b0; inj = 0; in_test = 0;
        setup(vecs[0]);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, done, wb.cyc}), 64'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset in the middle of the read phase, then a clean rerun.
        setup(vecs[0]);
        pulse_start();
        reached = 0;
        for (int k = 0; k < 500 && !reached; k++) begin
            @(negedge clk);
            reached = (rd_acc >= 3);
        end
        check("reached_read", 64'(reached), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);

        check("wrap_addr0", 64'(cap_addr[0]), 64'h00FF_FFFE);
        check("wrap_addr1", 64'(cap_addr[1]), 64'h00FF_FFFF);
        check("wrap_addr2", 64'(cap_addr[2]), 64'h0000_0000);
        check("wrap_addr3", 64'(cap_addr[3]), 64'h0000_0001);
        check("pat_data0",  64'(cap_data[0]), 64'h1234_57DD_1234_56DD);
        check("pat_data1",  64'(cap_data[1]), 64'h1235_57DD_1235_56DD);
        check("pat_data2",  64'(cap_data[2]), 64'h1236_57DD_1236_56DD);
        check("pat_data3",  64'(cap_data[3]), 64'h1237_57DD_1237_56DD);

        // A stray ack carrying bad data while DONE must not disturb the result.
        inj = 1;
        repeat (3) @(negedge clk);
        check("late_ack err",  64'(err_count), 64'd0);
        check("late_ack pass", 64'(pass),      64'd1);
        check("late_ack done", 64'(done),      64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
